// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP controller with BYPASS, IDCODE and one user data register.
// State and shift registers advance on posedge TCK; TDO and parallel outputs update on negedge.
module jtag_tap_param #(
   parameter int              IR_W       = 4,
   parameter int              DR_W       = 8,
   parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
   parameter logic [IR_W-1:0] IDCODE_OP  = IR_W'(4'b0001),
   parameter logic [IR_W-1:0] USER_OP    = IR_W'(4'b1001)
) (
   input  logic            TCK,
   input  logic            TRST,
   input  logic            TMS,
   input  logic            TDI,
   output logic            TDO,
   output logic            TDO_EN,
   output logic [3:0]      tap_state,
   output logic [IR_W-1:0] ir_out,
   input  logic [DR_W-1:0] user_capture,
   output logic [DR_W-1:0] user_dr,
   output logic            user_update,
   output logic            tlr
);

   typedef enum logic [3:0] {
      ST_TLR    = 4'hF,
      ST_RTI    = 4'hC,
      ST_SEL_DR = 4'h7,
      ST_CAP_DR = 4'h6,
      ST_SH_DR  = 4'h2,
      ST_EX1_DR = 4'h1,
      ST_PA_DR  = 4'h3,
      ST_EX2_DR = 4'h0,
      ST_UPD_DR = 4'h5,
      ST_SEL_IR = 4'h4,
      ST_CAP_IR = 4'hE,
      ST_SH_IR  = 4'hA,
      ST_EX1_IR = 4'h9,
      ST_PA_IR  = 4'hB,
      ST_EX2_IR = 4'h8,
      ST_UPD_IR = 4'hD
   } state_t;

   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

   state_t          state;
   state_t          next_state;

   logic            in_tlr;
   logic            cap_ir;
   logic            sh_ir;
   logic            upd_ir;
   logic            cap_dr;
   logic            sh_dr;
   logic            upd_dr;

   logic            sel_user;
   logic            sel_id;

   logic [IR_W-1:0] ir_sh;
   logic            bypass_sh;
   logic [31:0]     id_sh;
   logic [DR_W-1:0] user_sh;
   logic [DR_W-1:0] user_shifted;
   logic            dr_lsb;

   // TAP state register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         state <= ST_TLR;
      end else begin
         state <= next_state;
      end
   end

   // IEEE 1149.1 next-state function
   always_comb begin
      next_state = ST_TLR;
      case (state)
         ST_TLR:    next_state = TMS ? ST_TLR    : ST_RTI;
         ST_RTI:    next_state = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: next_state = TMS ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: next_state = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  next_state = TMS ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: next_state = TMS ? ST_UPD_DR : ST_PA_DR;
         ST_PA_DR:  next_state = TMS ? ST_EX2_DR : ST_PA_DR;
         ST_EX2_DR: next_state = TMS ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: next_state = TMS ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: next_state = TMS ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: next_state = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  next_state = TMS ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: next_state = TMS ? ST_UPD_IR : ST_PA_IR;
         ST_PA_IR:  next_state = TMS ? ST_EX2_IR : ST_PA_IR;
         ST_EX2_IR: next_state = TMS ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: next_state = TMS ? ST_SEL_DR : ST_RTI;
         default:   next_state = ST_TLR;
      endcase
   end

   // State decode into per-phase strobes
   always_comb begin
      in_tlr = 1'b0;
      cap_ir = 1'b0;
      sh_ir  = 1'b0;
      upd_ir = 1'b0;
      cap_dr = 1'b0;
      sh_dr  = 1'b0;
      upd_dr = 1'b0;
      case (state)
         ST_TLR:    in_tlr = 1'b1;
         ST_CAP_IR: cap_ir = 1'b1;
         ST_SH_IR:  sh_ir  = 1'b1;
         ST_UPD_IR: upd_ir = 1'b1;
         ST_CAP_DR: cap_dr = 1'b1;
         ST_SH_DR:  sh_dr  = 1'b1;
         ST_UPD_DR: upd_dr = 1'b1;
         default:   in_tlr = 1'b0;
      endcase
   end

   assign tap_state = state;
   assign tlr       = in_tlr;

   // Instruction decode; any unrecognised opcode falls through to BYPASS
   always_comb begin
      sel_user = 1'b0;
      sel_id   = 1'b0;
      if (ir_out == USER_OP) begin
         sel_user = 1'b1;
      end else if (ir_out == IDCODE_OP) begin
         sel_id = 1'b1;
      end else begin
         sel_user = 1'b0;
         sel_id   = 1'b0;
      end
   end

   generate
      if (DR_W > 1) begin : g_user_wide
         assign user_shifted = {TDI, user_sh[DR_W-1:1]};
      end else begin : g_user_narrow
         assign user_shifted = TDI;
      end
   endgenerate

   // Instruction shift register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_sh <= {IR_W{1'b0}};
      end else if (cap_ir) begin
         ir_sh <= IR_CAPTURE;
      end else if (sh_ir) begin
         ir_sh <= {TDI, ir_sh[IR_W-1:1]};
      end else begin
         ir_sh <= ir_sh;
      end
   end

   // Data shift registers: only the selected one captures or shifts, the rest hold
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         bypass_sh <= 1'b0;
         id_sh     <= 32'h0000_0000;
         user_sh   <= {DR_W{1'b0}};
      end else if (cap_dr) begin
         if (sel_user) begin
            user_sh <= user_capture;
         end else if (sel_id) begin
            id_sh <= IDCODE_VAL;
         end else begin
            bypass_sh <= 1'b0;
         end
      end else if (sh_dr) begin
         if (sel_user) begin
            user_sh <= user_shifted;
         end else if (sel_id) begin
            id_sh <= {TDI, id_sh[31:1]};
         end else begin
            bypass_sh <= TDI;
         end
      end else begin
         bypass_sh <= bypass_sh;
      end
   end

   // LSB of the currently selected data register
   always_comb begin
      if (sel_user) begin
         dr_lsb = user_sh[0];
      end else if (sel_id) begin
         dr_lsb = id_sh[0];
      end else begin
         dr_lsb = bypass_sh;
      end
   end

   // TDO and its enable launch on the falling edge
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         TDO    <= 1'b0;
         TDO_EN <= 1'b0;
      end else begin
         TDO_EN <= sh_ir | sh_dr;
         if (sh_ir) begin
            TDO <= ir_sh[0];
         end else if (sh_dr) begin
            TDO <= dr_lsb;
         end else begin
            TDO <= 1'b0;
         end
      end
   end

   // Active instruction; TLR restores IDCODE so the ID is readable right after reset
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_out <= IDCODE_OP;
      end else if (in_tlr) begin
         ir_out <= IDCODE_OP;
      end else if (upd_ir) begin
         ir_out <= ir_sh;
      end else begin
         ir_out <= ir_out;
      end
   end

   // User parallel register and its one-period update strobe
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         user_dr     <= {DR_W{1'b0}};
         user_update <= 1'b0;
      end else begin
         user_update <= upd_dr & sel_user;
         if (upd_dr && sel_user) begin
            user_dr <= user_sh;
         end else begin
            user_dr <= user_dr;
         end
      end
   end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: reset, IDCODE, IR scan with pause, user DR, BYPASS,
// TMS-driven TLR entry and asynchronous TRST mid-shift.
module tb_jtag_tap_param;

   logic       TCK = 1'b0;
   logic       TRST;
   logic       TMS;
   logic       TDI;
   logic       TDO;
   logic       TDO_EN;
   logic [3:0] tap_state;
   logic [3:0] ir_out;
   logic [7:0] user_capture;
   logic [7:0] user_dr;
   logic       user_update;
   logic       tlr;

   int checks = 0;
   int passed = 0;

   jtag_tap_param dut (
      .TCK          (TCK),
      .TRST         (TRST),
      .TMS          (TMS),
      .TDI          (TDI),
      .TDO          (TDO),
      .TDO_EN       (TDO_EN),
      .tap_state    (tap_state),
      .ir_out       (ir_out),
      .user_capture (user_capture),
      .user_dr      (user_dr),
      .user_update  (user_update),
      .tlr          (tlr)
   );

   always #10 TCK = ~TCK;

   // Drive TMS/TDI, let one posedge act, return 1 time unit after the following negedge.
   task automatic tck_cycle(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      #1;
      @(negedge TCK);
      #1;
   endtask

   // Full IR scan from RTI back to RTI
   task automatic load_ir(input logic [3:0] op);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tck_cycle(i == 3, op[i]);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; user_capture = 8'h00;
      repeat (2) @(negedge TCK);
      #1;
      TRST = 1'b0;
      checks++; if (tap_state !== 4'hF) $display("FAIL reset_state got %h want %h", tap_state, 4'hF); else passed++;
      checks++; if (ir_out !== 4'b0001) $display("FAIL reset_ir got %b want %b", ir_out, 4'b0001); else passed++;
      checks++; if (TDO_EN !== 1'b0 || TDO !== 1'b0) $display("FAIL reset_tdo got en=%b tdo=%b want 0 0", TDO_EN, TDO); else passed++;
      checks++; if (user_dr !== 8'h00 || user_update !== 1'b0) $display("FAIL reset_user got %h/%b want 00/0", user_dr, user_update); else passed++;
      checks++; if (tlr !== 1'b1) $display("FAIL reset_tlr got %b want 1", tlr); else passed++;
      repeat (5) tck_cycle(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF || TDO_EN !== 1'b0) $display("FAIL tms5_tlr got %h en=%b want F en=0", tap_state, TDO_EN); else passed++;
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hC || tlr !== 1'b0) $display("FAIL rti_entry got %h tlr=%b want C tlr=0", tap_state, tlr); else passed++;
   endtask

   task automatic test_idcode();
      logic [31:0] got;
      int          en_cnt;
      got = 32'h0;
      en_cnt = 0;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'h6 || TDO_EN !== 1'b0) $display("FAIL cap_dr got %h en=%b want 6 en=0", tap_state, TDO_EN); else passed++;
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         got[i] = TDO;
         if (TDO_EN) en_cnt++;
         tck_cycle(i == 31, 1'b0);
      end
      checks++; if (got !== 32'h1234_5001) $display("FAIL idcode_stream got %h want %h", got, 32'h1234_5001); else passed++;
      checks++; if (en_cnt !== 32) $display("FAIL idcode_en_count got %0d want 32", en_cnt); else passed++;
      checks++; if (tap_state !== 4'h1 || TDO_EN !== 1'b0) $display("FAIL idcode_exit got %h en=%b want 1 en=0", tap_state, TDO_EN); else passed++;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_ir_pause();
      logic b0;
      logic b1;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hA || TDO_EN !== 1'b1) $display("FAIL sh_ir_entry got %h en=%b want A en=1", tap_state, TDO_EN); else passed++;
      b0 = TDO;
      tck_cycle(1'b0, 1'b1);
      b1 = TDO;
      tck_cycle(1'b1, 1'b0);
      checks++; if ({b1, b0} !== 2'b01) $display("FAIL ir_capture_bits got %b want %b", {b1, b0}, 2'b01); else passed++;
      repeat (6) tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hB || ir_out !== 4'b0001) $display("FAIL pa_ir_hold got %h ir=%b want B ir=0001", tap_state, ir_out); else passed++;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hA || TDO !== 1'b0) $display("FAIL sh_ir_resume got %h tdo=%b want A tdo=0", tap_state, TDO); else passed++;
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b1, 1'b1);
      checks++; if (ir_out !== 4'b0001) $display("FAIL ir_before_update got %b want %b", ir_out, 4'b0001); else passed++;
      tck_cycle(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hD || ir_out !== 4'b1001) $display("FAIL ir_update got %h ir=%b want D ir=1001", tap_state, ir_out); else passed++;
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_user_dr();
      logic [7:0] got;
      logic [7:0] pat;
      got = 8'h00;
      pat = 8'h81;
      user_capture = 8'hC3;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         got[i] = TDO;
         tck_cycle(i == 3, pat[i]);
      end
      repeat (4) tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'h3 || user_dr !== 8'h00) $display("FAIL pa_dr_hold got %h udr=%h want 3 udr=00", tap_state, user_dr); else passed++;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 4; i < 8; i++) begin
         got[i] = TDO;
         tck_cycle(i == 7, pat[i]);
      end
      checks++; if (got !== 8'hC3) $display("FAIL user_capture_stream got %h want %h", got, 8'hC3); else passed++;
      checks++; if (user_update !== 1'b0) $display("FAIL user_update_early got %b want 0", user_update); else passed++;
      tck_cycle(1'b1, 1'b0);
      checks++; if (user_dr !== 8'h81 || user_update !== 1'b1) $display("FAIL user_update got %h/%b want 81/1", user_dr, user_update); else passed++;
      tck_cycle(1'b0, 1'b0);
      checks++; if (user_update !== 1'b0 || user_dr !== 8'h81) $display("FAIL user_pulse_end got %h/%b want 81/0", user_dr, user_update); else passed++;
   endtask

   task automatic test_bypass();
      logic [4:0] pat;
      logic [4:0] got;
      pat = 5'b01101;
      got = 5'b00000;
      load_ir(4'b1111);
      checks++; if (ir_out !== 4'b1111) $display("FAIL bypass_ir got %b want %b", ir_out, 4'b1111); else passed++;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         got[i] = TDO;
         tck_cycle(i == 4, pat[i]);
      end
      checks++; if (got !== 5'b11010) $display("FAIL bypass_delay got %b want %b", got, 5'b11010); else passed++;
      tck_cycle(1'b1, 1'b0);
      checks++; if (user_update !== 1'b0 || user_dr !== 8'h81) $display("FAIL bypass_no_update got %h/%b want 81/0", user_dr, user_update); else passed++;
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_tms_tlr();
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++; if (tap_state !== 4'h3) $display("FAIL pa_dr_reach got %h want 3", tap_state); else passed++;
      repeat (5) tck_cycle(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF || ir_out !== 4'b0001) $display("FAIL tms_tlr got %h ir=%b want F ir=0001", tap_state, ir_out); else passed++;
      checks++; if (user_dr !== 8'h81) $display("FAIL tlr_keeps_user got %h want %h", user_dr, 8'h81); else passed++;
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_trst_mid_shift();
      load_ir(4'b1001);
      user_capture = 8'h5A;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      repeat (3) tck_cycle(1'b0, 1'b1);
      checks++; if (tap_state !== 4'h2 || TDO_EN !== 1'b1) $display("FAIL pre_trst got %h en=%b want 2 en=1", tap_state, TDO_EN); else passed++;
      TRST = 1'b1;
      TMS = 1'b1;
      #1;
      checks++; if (tap_state !== 4'hF || tlr !== 1'b1) $display("FAIL trst_async_state got %h tlr=%b want F tlr=1", tap_state, tlr); else passed++;
      checks++; if (user_dr !== 8'h00 || TDO_EN !== 1'b0 || TDO !== 1'b0) $display("FAIL trst_async_out got udr=%h en=%b tdo=%b want 00 0 0", user_dr, TDO_EN, TDO); else passed++;
      checks++; if (ir_out !== 4'b0001) $display("FAIL trst_async_ir got %b want %b", ir_out, 4'b0001); else passed++;
      #3;
      TRST = 1'b0;
      @(negedge TCK);
      #1;
      checks++; if (tap_state !== 4'hF) $display("FAIL trst_release got %h want F", tap_state); else passed++;
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_ir_pause();
      test_user_dr();
      test_bypass();
      test_tms_tlr();
      test_trst_mid_shift();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
- Parametrised IEEE 1149.1 TAP controller; next generation of the `ics` TAP.
- Adds the following over `ics`:
  - configurable IR width;
  - decoded instruction set with BYPASS, IDCODE and one user data register of configurable width;
  - capture/update hooks for the user register.
- Sits between the board JTAG pins and on-chip debug/config logic, all in the TCK domain.

Parameters:
- IR_W, 4, instruction register width (>=2).
- DR_W, 8, user data register width (>=1).
- IDCODE_VAL, 32'h1234_5001, value captured by IDCODE; bit 0 must be 1.
- IDCODE_OP, 4'b0001, IDCODE opcode (IR_W bits).
- USER_OP, 4'b1001, user DR opcode (IR_W bits).

Ports:
- TCK  in  1  JTAG clock; state/shift on posedge, TDO/update on negedge.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in, sampled on posedge TCK.
- TDO  out  1  serial data out, changes on negedge TCK.
- TDO_EN  out  1  high while TDO is driving valid shift data.
- tap_state  out  4  current TAP state, IEEE encoding.
- ir_out  out  IR_W  active instruction.
- user_capture  in  DR_W  parallel value loaded in Capture-DR under USER_OP.
- user_dr  out  DR_W  parallel user register, updated in Update-DR.
- user_update  out  1  one-TCK-period strobe marking a user_dr update.
- tlr  out  1  high while in Test-Logic-Reset.

Behaviour:
- State encoding, 16 states:
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D
- Transitions on posedge TCK per IEEE 1149.1; TMS=1 for 5 consecutive posedges reaches TLR from any state.
- Reset, TRST=1 (asynchronous; also applies mid-shift):
  - tap_state=F, ir_out=IDCODE_OP, user_dr=0, user_update=0, TDO=0, TDO_EN=0, tlr=1.
  - All shift registers cleared.
- Entering TLR via TMS also forces ir_out=IDCODE_OP; user_dr is kept.
- Instruction decode:
  - ir_out==IDCODE_OP selects the 32-bit ID register.
  - ir_out==USER_OP selects the DR_W user register.
  - All other opcodes, including all-ones, select the 1-bit BYPASS register.
- CAP_IR: IR shift register loads {zeros, 2'b01}.
- SH_IR:
  - Each posedge shifts right; TDI enters the MSB.
  - TDO presents the LSB at the following negedge.
- UPD_IR: ir_out loads the IR shift register at the negedge while in UPD_IR.
- CAP_DR loads the selected register:
  - BYPASS <- 0
  - ID <- IDCODE_VAL
  - USER <- user_capture, sampled at the posedge leaving CAP_DR.
- SH_DR: the selected register shifts right, TDI into MSB, LSB to TDO at negedge.
  - BYPASS gives exactly one TCK of delay TDI->TDO.
- Pause/Exit states: shift register contents are held unchanged; re-entering SH_* resumes shifting with no bit lost or duplicated.
- UPD_DR:
  - Under USER_OP: user_dr loads the user shift register at the negedge in UPD_DR; user_update is high from that negedge to the next negedge.
  - Under other opcodes: no parallel output changes.
- TDO_EN is registered at negedge and is high only if tap_state is SH_IR or SH_DR. Otherwise TDO=0, TDO_EN=0.
- Instruction change takes effect only at UPD_IR; an instruction shifted but aborted via TLR never reaches ir_out.
- tap_state and tlr are combinational from the state register; no extra latency.

Test Plan:
1. TRST pulse, then TMS=1 x5 -> tap_state=F, ir_out=4'b0001, TDO_EN=0.
   - Then TMS=0 -> tap_state=C.
2. From RTI, TMS 1,0,0 -> CAP_DR, SH_DR; shift 32 bits with TDI=0 -> TDO stream equals 32'h1234_5001 LSB first, TDO_EN high for exactly those 32 negedges.
3. From RTI:
   - TMS 1,1,0,0 enters SH_IR; shift 4 bits, the last with TMS=1 -> first 2 TDO bits are 1,0 (capture 01).
   - Pass through PA_IR x6, EX2_IR, back to SH_IR, finish; UPD_IR with bits LSB-first 1,0,0,1 -> ir_out=4'b1001 at the UPD_IR negedge.
4. USER_OP loaded, user_capture=8'hC3:
   - Shift DR 0x81 with a 4-cycle PA_DR gap mid-shift, then UPD_DR -> TDO returns 0xC3 LSB first, user_dr=8'h81, user_update a single 1-TCK pulse.
5. IR=4'b1111 (BYPASS), shift TDI pattern 1,0,1,1,0 -> TDO shows the same pattern delayed one TCK, first bit 0.
6. Assert TRST mid-SH_DR under USER_OP -> tap_state=F immediately (asynchronous), user_dr=0, TDO_EN=0, ir_out=IDCODE_OP.
